match_counter: RTL and testbench
================================

MATCH_COUNTER -- requirements
Module: match_counter

Interface
REQ-001 SHALL declare parameter WRAP, default 0: 0 = saturate at 99, 1 = wrap 99 -> 00.
REQ-002 SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port match_in, input, 1 bit: detector output level, synchronous to clock.
REQ-005 SHALL have port clear, input, 1 bit: synchronous counter clear.
REQ-006 SHALL have port hold, input, 1 bit: freezes counting while high.
REQ-007 SHALL have port count_ones, output, 4 bits: BCD units digit, registered.
REQ-008 SHALL have port count_tens, output, 4 bits: BCD tens digit, registered.
REQ-009 SHALL have port match_pulse, output, 1 bit: registered one-cycle pulse per accepted event.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set on an event at count 99.

Function
REQ-011 SHALL hold a registered copy match_d of match_in, updated every rising edge.
- event = match_in & ~match_d; a level held N cycles counts once.
REQ-012 SHALL accept an event only when hold=0 and clear=0.
- Events arriving while hold=1 are discarded, not deferred.
REQ-013 SHALL update the count on the same edge that samples the event (1-cycle latency).
- New value visible in the following cycle, coincident with match_pulse=1 for exactly one cycle.
REQ-014 SHALL increment in BCD:
- ones 9 -> 0 with tens+1.
- count_ones and count_tens never hold values above 9.
REQ-015 SHALL, on an accepted event at 99:
- WRAP=0: keep 99.
- WRAP=1: go to 00.
- Either case: set overflow=1 and assert match_pulse.
REQ-016 SHALL keep overflow set until clear or reset.
REQ-017 SHALL give clear priority over event and hold:
- On that edge: count=00, overflow=0, match_pulse=0.
- match_d still updates.
- A match_in rising edge coincident with clear is lost.
REQ-018 SHALL treat a rising edge of match_in coincident with hold falling as discarded (hold sampled high).
REQ-019 SHALL keep all outputs constant when no event, clear or reset occurs.

Reset
REQ-020 SHALL, on reset=1 and independent of clock, force count_ones=0, count_tens=0, match_pulse=0, overflow=0, match_d=0.
REQ-021 SHALL treat match_in=1 at the first edge after reset release as a rising edge, which counts once.
REQ-022 SHALL abort any in-progress pulse when reset asserts mid-operation, with no residual increment after release.

Configuration
REQ-023 SHALL, when macro MATCH_COUNTER_SEVEN_SEG_EN is defined:
- Add outputs hex0[6:0] (units) and hex1[6:0] (tens), active-low segments, order gfedcba.
- Register both, updated on the edge after the count changes.
- Reset value 7'b1000000, showing "0".
REQ-024 SHALL, when MATCH_COUNTER_SEVEN_SEG_EN is undefined, omit hex0/hex1 entirely, with all other behaviour identical.

Verification
REQ-025 SHALL cover single event: reset, then match_in high for 1 cycle -> count 01 next cycle, match_pulse high 1 cycle.
REQ-026 SHALL cover held level: match_in high 5 cycles -> count +1 only, one match_pulse.
REQ-027 SHALL cover BCD carry: 10 separated events from 00 -> tens=1, ones=0; after 9 events ones=9, tens=0.
REQ-028 SHALL cover the 99 boundary, 100 events:
- WRAP=0: count 99, overflow=1.
- WRAP=1: count 00, overflow=1.
- Then clear -> 00, overflow=0.
REQ-029 SHALL cover hold/clear priority:
- hold=1 with 3 events -> count unchanged.
- clear and event on the same edge -> count 00, match_pulse 0.
REQ-030 SHALL cover async reset mid-count: reset at count 47 between edges -> outputs 0 immediately; with SEVEN_SEG_EN, hex0=hex1=7'b1000000.

Source files
------------

// File: rtl/match_counter.sv
// Edge-triggered two-digit BCD event counter (00..99) with sticky overflow; optional 7-seg outputs via MATCH_COUNTER_SEVEN_SEG_EN.
// Latency: count and match_pulse update on the edge that samples the match_in rising edge; hex digits one edge later.
// Backpressure: none; hold discards (does not defer) events, clear wins over hold and events.
module match_counter #(
    parameter int WRAP = 0               // 0: saturate at 99, 1: wrap 99 -> 00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       match_in,
    input  logic       clear,
    input  logic       hold,
    output logic [3:0] count_ones,
    output logic [3:0] count_tens,
    output logic       match_pulse,
    output logic       overflow
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
    ,
    output logic [6:0] hex0,
    output logic [6:0] hex1
`endif
);

    logic       match_d_q, match_d_d;   // registered copy of match_in (match_d)
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       pulse_q, pulse_d;
    logic       ovf_q, ovf_d;

    logic       evt;
    logic       accept;
    logic       at_max;

    assign evt    = match_in & ~match_d_q;
    assign accept = evt & ~hold & ~clear;
    assign at_max = (ones_q == 4'd9) && (tens_q == 4'd9);

    // Next-state: clear first, then accepted event (saturate/wrap at 99), else hold everything.
    always_comb begin
        match_d_d = match_in;
        ones_d    = ones_q;
        tens_d    = tens_q;
        pulse_d   = 1'b0;
        ovf_d     = ovf_q;
        if (clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            ovf_d  = 1'b0;
        end else if (accept) begin
            pulse_d = 1'b1;
            if (at_max) begin
                ovf_d = 1'b1;
                if (WRAP != 0) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Counter state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match_d_q <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            pulse_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            match_d_q <= match_d_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            pulse_q   <= pulse_d;
            ovf_q     <= ovf_d;
        end
    end

    assign count_ones  = ones_q;
    assign count_tens  = tens_q;
    assign match_pulse = pulse_q;
    assign overflow    = ovf_q;

`ifdef MATCH_COUNTER_SEVEN_SEG_EN
    // Active-low segments, bit order gfedcba; digits above 9 never occur but blank the display.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b1111111;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [6:0] hex0_q, hex0_d;
    logic [6:0] hex1_q, hex1_d;

    // Decode from the registered count, so the display trails the count by one edge.
    always_comb begin
        hex0_d = seg7(ones_q);
        hex1_d = seg7(tens_q);
    end

    // Display registers; reset shows "00".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hex0_q <= 7'b1000000;
            hex1_q <= 7'b1000000;
        end else begin
            hex0_q <= hex0_d;
            hex1_q <= hex1_d;
        end
    end

    assign hex0 = hex0_q;
    assign hex1 = hex1_q;
`endif

endmodule

// File: tb/tb_match_counter.sv
// Directed bench for match_counter: runs a saturating and a wrapping instance side by side.
// Expected values are hand-computed per step; outputs sampled 1 time unit after the rising edge.
// Summary line reports passed/total checks.
module tb_match_counter;

    logic clock;
    logic reset;
    logic match_in;
    logic clear;
    logic hold;

    logic [3:0] s_ones, s_tens, w_ones, w_tens;
    logic       s_pulse, s_ovf, w_pulse, w_ovf;
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
    logic [6:0] s_hex0, s_hex1, w_hex0, w_hex1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    match_counter #(.WRAP(0)) u_sat (
        .clock      (clock),
        .reset      (reset),
        .match_in   (match_in),
        .clear      (clear),
        .hold       (hold),
        .count_ones (s_ones),
        .count_tens (s_tens),
        .match_pulse(s_pulse),
        .overflow   (s_ovf)
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
        ,
        .hex0       (s_hex0),
        .hex1       (s_hex1)
`endif
    );

    match_counter #(.WRAP(1)) u_wrap (
        .clock      (clock),
        .reset      (reset),
        .match_in   (match_in),
        .clear      (clear),
        .hold       (hold),
        .count_ones (w_ones),
        .count_tens (w_tens),
        .match_pulse(w_pulse),
        .overflow   (w_ovf)
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
        ,
        .hex0       (w_hex0),
        .hex1       (w_hex1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated event: one cycle high, one cycle low.
    task automatic evt();
        match_in = 1'b1;
        tick();
        match_in = 1'b0;
        tick();
    endtask

    task automatic chk_cnt(input string tag, input int sat, input int wrp);
        check({tag, "_sat_ones"},  32'(s_ones), 32'(sat % 10));
        check({tag, "_sat_tens"},  32'(s_tens), 32'(sat / 10));
        check({tag, "_wrap_ones"}, 32'(w_ones), 32'(wrp % 10));
        check({tag, "_wrap_tens"}, 32'(w_tens), 32'(wrp / 10));
    endtask

    task automatic chk_flags(input string tag, input logic pulse, input logic ovf_s, input logic ovf_w);
        check({tag, "_sat_pulse"},  32'(s_pulse), 32'(pulse));
        check({tag, "_wrap_pulse"}, 32'(w_pulse), 32'(pulse));
        check({tag, "_sat_ovf"},    32'(s_ovf),   32'(ovf_s));
        check({tag, "_wrap_ovf"},   32'(w_ovf),   32'(ovf_w));
    endtask

`ifdef MATCH_COUNTER_SEVEN_SEG_EN
    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk_hex(input string tag, input int sat, input int wrp);
        check({tag, "_sat_hex0"},  32'(s_hex0), 32'(seg(sat % 10)));
        check({tag, "_sat_hex1"},  32'(s_hex1), 32'(seg(sat / 10)));
        check({tag, "_wrap_hex0"}, 32'(w_hex0), 32'(seg(wrp % 10)));
        check({tag, "_wrap_hex1"}, 32'(w_hex1), 32'(seg(wrp / 10)));
    endtask
`endif

    initial begin
        int npulse;
        reset    = 1'b1;
        match_in = 1'b0;
        clear    = 1'b0;
        hold     = 1'b0;
        #2;
        // Reset state
        chk_cnt("rst", 0, 0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
        chk_hex("rst", 0, 0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // Single event: count 01 with a one-cycle pulse
        match_in = 1'b1;
        tick();
        chk_cnt("single", 1, 1);
        chk_flags("single", 1'b1, 1'b0, 1'b0);
        match_in = 1'b0;
        tick();
        chk_cnt("single_after", 1, 1);
        chk_flags("single_after", 1'b0, 1'b0, 1'b0);

        // Held level for 5 cycles counts once
        npulse = 0;
        match_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_pulse) npulse++;
        end
        match_in = 1'b0;
        tick();
        check("held_pulses", 32'(npulse), 32'd1);
        chk_cnt("held", 2, 2);

        // BCD carry from 00
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_cnt("clr1", 0, 0);
        for (int i = 0; i < 9; i++) evt();
        chk_cnt("nine", 9, 9);
        evt();
        chk_cnt("ten", 10, 10);
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
        chk_hex("ten", 10, 10);
`endif

        // 99 boundary: clear, then 100 events
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 99; i++) evt();
        chk_cnt("n99", 99, 99);
        chk_flags("n99", 1'b0, 1'b0, 1'b0);
        match_in = 1'b1;
        tick();
        chk_cnt("n100", 99, 0);
        chk_flags("n100", 1'b1, 1'b1, 1'b1);
        match_in = 1'b0;
        tick();
        evt();
        chk_cnt("n101", 99, 1);
        chk_flags("n101", 1'b0, 1'b1, 1'b1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_cnt("ovf_clr", 0, 0);
        chk_flags("ovf_clr", 1'b0, 1'b0, 1'b0);

        // Hold discards events
        for (int i = 0; i < 3; i++) evt();
        chk_cnt("pre_hold", 3, 3);
        hold = 1'b1;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            match_in = 1'b1;
            tick();
            if (s_pulse | w_pulse) npulse++;
            match_in = 1'b0;
            tick();
        end
        check("hold_pulses", 32'(npulse), 32'd0);
        chk_cnt("hold", 3, 3);
        // Rising edge sampled together with hold still high, hold drops after
        match_in = 1'b1;
        tick();
        hold = 1'b0;
        tick();
        chk_cnt("hold_fall", 3, 3);
        chk_flags("hold_fall", 1'b0, 1'b0, 1'b0);
        match_in = 1'b0;
        tick();

        // Clear and event on the same edge: event lost
        match_in = 1'b1;
        clear    = 1'b1;
        tick();
        chk_cnt("clr_evt", 0, 0);
        chk_flags("clr_evt", 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();
        chk_cnt("clr_evt_after", 0, 0);
        check("clr_evt_after_pulse", 32'(s_pulse), 32'd0);
        match_in = 1'b0;
        tick();

        // Async reset mid-count at 47, during the pulse
        for (int i = 0; i < 46; i++) evt();
        match_in = 1'b1;
        tick();
        chk_cnt("c47", 47, 47);
        check("c47_pulse", 32'(s_pulse), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_cnt("async_rst", 0, 0);
        chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
`ifdef MATCH_COUNTER_SEVEN_SEG_EN
        chk_hex("async_rst", 0, 0);
`endif
        match_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        tick();
        chk_cnt("post_rst", 0, 0);
        chk_flags("post_rst", 1'b0, 1'b0, 1'b0);

        // match_in high across reset release counts once
        reset    = 1'b1;
        match_in = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk_cnt("rel_high", 1, 1);
        check("rel_high_pulse", 32'(w_pulse), 32'd1);
        tick();
        chk_cnt("rel_high2", 1, 1);
        match_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
